piezo_note_sequencer: RTL and testbench

- Upstream stage of the piezo tone driver. Walks a note table held in an external synchronous ROM, one entry per note.
- For each note it drives the tone-enable and half-period divider that the tone driver consumes. It times each note in duration ticks and inserts a fixed silent gap between notes.
- It is started and stopped by the game/UI control logic, and flags completion when it reaches an end-of-melody entry.

---
 rtl/piezo_note_sequencer.sv | 144 ++++++++++++++
 tb/tb_piezo_note_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/piezo_note_sequencer.sv
// rtl/piezo_note_sequencer.sv - walks a note ROM and drives the piezo tone driver
module piezo_note_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int TICK_CYCLES = 2500000,
   parameter int GAP_CYCLES  = 250000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] note_addr,
   input  logic [23:0]       note_data,
   output logic              piezo_en,
   output logic [19:0]       freq_div,
   output logic              busy,
   output logic              done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_PLAY  = 3'd3;
   localparam logic [2:0] S_GAP   = 3'd4;

   // One shared counter times both the duration prescaler and the gap
   localparam int CNT_MAX    = (TICK_CYCLES > GAP_CYCLES) ? TICK_CYCLES : GAP_CYCLES;
   localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LAST_I);

   logic [2:0]        state_q,     state_d;
   logic [ADDR_W-1:0] note_addr_q, note_addr_d;
   logic [19:0]       freq_div_q,  freq_div_d;
   logic              piezo_en_q,  piezo_en_d;
   logic [3:0]        dur_q,       dur_d;
   logic [CNT_W-1:0]  presc_q,     presc_d;

   logic [3:0]        rom_dur;
   logic [19:0]       rom_div;

   assign rom_dur = note_data[23:20];
   assign rom_div = note_data[19:0];

   // Next-state logic; stop overrides whatever the state would have done
   always_comb begin
      state_d     = state_q;
      note_addr_d = note_addr_q;
      freq_div_d  = freq_div_q;
      piezo_en_d  = piezo_en_q;
      dur_d       = dur_q;
      presc_d     = presc_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               note_addr_d = start_addr;
               state_d     = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (rom_dur == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               freq_div_d = rom_div;
               piezo_en_d = (rom_div != 20'd0);
               dur_d      = rom_dur;
               presc_d    = '0;
               state_d    = S_PLAY;
            end
         end
         S_PLAY: begin
            if (presc_q == TICK_LAST) begin
               presc_d = '0;
               if (dur_q == 4'd1) begin
                  dur_d      = 4'd0;
                  piezo_en_d = 1'b0;
                  freq_div_d = 20'd0;
                  if (GAP_CYCLES > 0) begin
                     state_d = S_GAP;
                  end else begin
                     note_addr_d = note_addr_q + ADDR_W'(1);
                     state_d     = S_FETCH;
                  end
               end else begin
                  dur_d = dur_q - 4'd1;
               end
            end else begin
               presc_d = presc_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (presc_q == GAP_LAST) begin
               presc_d     = '0;
               note_addr_d = note_addr_q + ADDR_W'(1);
               state_d     = S_FETCH;
            end else begin
               presc_d = presc_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (stop) begin
         state_d    = S_IDLE;
         piezo_en_d = 1'b0;
         freq_div_d = 20'd0;
         dur_d      = 4'd0;
         presc_d    = '0;
      end
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         note_addr_q <= '0;
         freq_div_q  <= 20'd0;
         piezo_en_q  <= 1'b0;
         dur_q       <= 4'd0;
         presc_q     <= '0;
      end else begin
         state_q     <= state_d;
         note_addr_q <= note_addr_d;
         freq_div_q  <= freq_div_d;
         piezo_en_q  <= piezo_en_d;
         dur_q       <= dur_d;
         presc_q     <= presc_d;
      end
   end

   assign note_addr = note_addr_q;
   assign piezo_en  = piezo_en_q;
   assign freq_div  = freq_div_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_LOAD) && (rom_dur == 4'd0) && !stop;

endmodule

// File: tb/tb_piezo_note_sequencer.sv
// tb/tb_piezo_note_sequencer.sv - directed bench for piezo_note_sequencer
module tb_piezo_note_sequencer;

   logic        clk;
   logic        rst;
   logic        start_a, start_z, stop;
   logic [7:0]  start_addr;
   logic [7:0]  na_a, na_z;
   logic [23:0] data_a, data_z;
   logic        pz_a, pz_z, bz_a, bz_z, dn_a, dn_z;
   logic [19:0] fd_a, fd_z;

   logic [23:0] rom [0:255];

   int nerr = 0;
   int nchk = 0;
   int inv_viol = 0;

   logic        tr_pz [0:63];
   logic        tr_bz [0:63];
   logic        tr_dn [0:63];
   logic [19:0] tr_fd [0:63];
   logic [7:0]  tr_na [0:63];

   piezo_note_sequencer #(.ADDR_W(8), .TICK_CYCLES(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start_a), .stop(stop), .start_addr(start_addr),
      .note_addr(na_a), .note_data(data_a), .piezo_en(pz_a), .freq_div(fd_a),
      .busy(bz_a), .done(dn_a)
   );

   piezo_note_sequencer #(.ADDR_W(8), .TICK_CYCLES(4), .GAP_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst), .start(start_z), .stop(stop), .start_addr(start_addr),
      .note_addr(na_z), .note_data(data_z), .piezo_en(pz_z), .freq_div(fd_z),
      .busy(bz_z), .done(dn_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      data_a <= rom[na_a];
      data_z <= rom[na_z];
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (fd_a != 20'd0 && !pz_a) inv_viol = inv_viol + 1;
         if (fd_z != 20'd0 && !pz_z) inv_viol = inv_viol + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk = nchk + 1;
      if (got !== exp) begin
         nerr = nerr + 1;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Starts from a negedge; records n cycles sampled at successive negedges
   task automatic run_trace(input bit use_z, input logic [7:0] sa, input int n);
      start_addr = sa;
      if (use_z) start_z = 1'b1;
      else       start_a = 1'b1;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         start_a = 1'b0;
         start_z = 1'b0;
         @(negedge clk);
         tr_pz[k] = use_z ? pz_z : pz_a;
         tr_fd[k] = use_z ? fd_z : fd_a;
         tr_bz[k] = use_z ? bz_z : bz_a;
         tr_dn[k] = use_z ? dn_z : dn_a;
         tr_na[k] = use_z ? na_z : na_a;
      end
   endtask

   task automatic chk_trace(input string name, input int n,
                            input int lo1, input int hi1, input int f1,
                            input int lo2, input int hi2, input int f2,
                            input int done_k, input int busy_hi);
      logic        e_pz;
      logic [19:0] e_fd;
      for (int k = 1; k <= n; k++) begin
         e_pz = 1'b0;
         e_fd = 20'd0;
         if (k >= lo1 && k <= hi1) begin e_pz = (f1 != 0); e_fd = 20'(f1); end
         if (k >= lo2 && k <= hi2) begin e_pz = (f2 != 0); e_fd = 20'(f2); end
         check($sformatf("%s_pz_k%0d", name, k), 32'(tr_pz[k]), 32'(e_pz));
         check($sformatf("%s_fd_k%0d", name, k), 32'(tr_fd[k]), 32'(e_fd));
         check($sformatf("%s_busy_k%0d", name, k), 32'(tr_bz[k]), 32'(k <= busy_hi));
         check($sformatf("%s_done_k%0d", name, k), 32'(tr_dn[k]), 32'(k == done_k));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 24'h0;
      rom[0]  = {4'd2, 20'd100};
      rom[1]  = {4'd1, 20'd0};
      rom[2]  = {4'd0, 20'd0};
      rom[10] = {4'd15, 20'd777};
      rom[11] = {4'd0, 20'd0};
      rom[20] = {4'd0, 20'd500};
      rom[30] = {4'd1, 20'd10};
      rom[31] = {4'd1, 20'd20};
      rom[32] = {4'd0, 20'd0};
      rom[255] = {4'd1, 20'd50};

      rst = 1'b1; start_a = 1'b0; start_z = 1'b0; stop = 1'b0; start_addr = 8'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst_pz", 32'(pz_a), 32'd0);
      check("rst_fd", 32'(fd_a), 32'd0);
      check("rst_busy", 32'(bz_a), 32'd0);
      check("rst_done", 32'(dn_a), 32'd0);
      check("rst_addr", 32'(na_a), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic melody: 2-tick tone, 1-tick rest, end entry
      run_trace(1'b0, 8'd0, 23);
      chk_trace("melody", 23, 3, 10, 100, 1, 0, 0, 22, 22);

      // Stop ten cycles into a 15-tick note
      run_trace(1'b0, 8'd10, 12);
      chk_trace("stop", 12, 3, 12, 777, 1, 0, 0, 0, 12);
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("stop_pz_%0d", k), 32'(pz_a), 32'd0);
         check($sformatf("stop_fd_%0d", k), 32'(fd_a), 32'd0);
         check($sformatf("stop_busy_%0d", k), 32'(bz_a), 32'd0);
         check($sformatf("stop_done_%0d", k), 32'(dn_a), 32'd0);
      end

      // Stop together with start in IDLE stays idle
      start_addr = 8'd0; start_a = 1'b1; stop = 1'b1;
      @(negedge clk);
      check("stopstart_busy", 32'(bz_a), 32'd0);
      start_a = 1'b0; stop = 1'b0;

      // Immediate end entry
      run_trace(1'b0, 8'd20, 3);
      chk_trace("imm", 3, 1, 0, 0, 1, 0, 0, 2, 2);

      // Address wrap 255 -> 0
      rom[0] = {4'd0, 20'd0};
      run_trace(1'b0, 8'd255, 11);
      chk_trace("wrap", 11, 3, 6, 50, 1, 0, 0, 10, 10);
      check("wrap_addr_k1", 32'(tr_na[1]), 32'd255);
      check("wrap_addr_k8", 32'(tr_na[8]), 32'd255);
      check("wrap_addr_k9", 32'(tr_na[9]), 32'd0);

      // Async reset mid-note, then restart with start held
      run_trace(1'b0, 8'd10, 5);
      check("prerst_pz", 32'(pz_a), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pz", 32'(pz_a), 32'd0);
      check("arst_fd", 32'(fd_a), 32'd0);
      check("arst_busy", 32'(bz_a), 32'd0);
      check("arst_addr", 32'(na_a), 32'd0);
      start_addr = 8'd10;
      start_a = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("held_addr_k%0d", k), 32'(na_a), 32'd10);
         check($sformatf("held_pz_k%0d", k), 32'(pz_a), 32'(k >= 3));
         check($sformatf("held_fd_k%0d", k), 32'(fd_a), (k >= 3) ? 32'd777 : 32'd0);
      end
      start_a = 1'b0;
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("held_stop_busy", 32'(bz_a), 32'd0);
      @(negedge clk);

      // Zero gap: notes back to back with only fetch/load between
      run_trace(1'b1, 8'd30, 15);
      chk_trace("zgap", 15, 3, 6, 10, 9, 12, 20, 14, 14);
      check("zgap_addr_k13", 32'(tr_na[13]), 32'd32);

      check("freq_without_en", 32'(inv_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
